// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command dispatcher: command bus field
// positions, reserved action codes, FSM state encoding and swap-word builder.
package sprite_cmd_pkg;

    localparam int COMP_MSB   = 31;
    localparam int COMP_LSB   = 26;
    localparam int CHILD_MSB  = 25;
    localparam int CHILD_LSB  = 21;
    localparam int ACT_MSB    = 20;
    localparam int ACT_LSB    = 17;
    localparam int TYPE_MSB   = 16;
    localparam int TYPE_LSB   = 14;
    localparam int TOGGLE_BIT = 13;
    localparam int DATA_MSB   = 12;

    localparam logic [3:0] ACT_SWAP   = 4'hF;
    localparam logic [3:0] ACT_UPDATE = 4'h1;
    localparam logic [5:0] IDLE_ID    = 6'd0;

    typedef logic [1:0] state_t;
    localparam state_t ST_DRAIN   = 2'd0;
    localparam state_t ST_WAIT_VB = 2'd1;
    localparam state_t ST_SWAP    = 2'd2;

    // Buffer-swap word for one component: child/type/data fields are zero.
    function automatic logic [31:0] swap_word(input logic [5:0] id, input logic buf_sel);
        logic [31:0] w;
        w                    = '0;
        w[COMP_MSB:COMP_LSB] = id;
        w[ACT_MSB:ACT_LSB]   = ACT_SWAP;
        w[TOGGLE_BIT]        = buf_sel;
        return w;
    endfunction

endpackage

// File: rtl/sprite_cmd_dispatcher_fifo.sv
// Synchronous FIFO with combinational head (show-ahead) and occupancy count.
module cmd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sprite_cmd_dispatcher.sv
// Avalon-MM command dispatcher: queues CPU command words and broadcasts them on the
// shared sprite command bus, owning the double-buffer index and vblank swap sequence.
module sprite_cmd_dispatcher
    import sprite_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_ID      = 15,
    parameter int VBLANK_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic        address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [32:0]   head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic [32:0]   push_data;
    logic          pop;

    state_t        state;
    logic [5:0]    id;
    logic          back_buf;
    logic [15:0]   frame_count;
    logic          drop_err;
    logic [31:0]   stage;
    logic [31:0]   fwd_word;
    logic [31:0]   status;

    logic          bus_ok;
    logic          wr_cmd;
    logic          wr_bad;
    logic          wr_commit;
    logic          rd_acc;
    logic          sof;

    // Handshake: waitrequest is the FIFO-full flag. A read or write is accepted
    // on a clock edge where chipselect and the strobe are high and waitrequest is
    // low; while waitrequest is high the host holds the request unchanged.
    assign waitrequest = fifo_full;
    assign bus_ok      = chipselect && !fifo_full;
    assign wr_cmd      = bus_ok && write && !address;
    assign wr_bad      = wr_cmd && (writedata[ACT_MSB:ACT_LSB] == ACT_SWAP);
    assign wr_commit   = bus_ok && write && address;
    assign rd_acc      = bus_ok && read;

    assign push      = (wr_cmd && !wr_bad) || wr_commit;
    assign push_data = wr_commit ? {1'b1, 32'h0} : {1'b0, writedata};
    assign pop       = (state == ST_DRAIN) && !fifo_empty;

    assign sof = (hcount == 10'd0) && (vcount == 10'(VBLANK_LINE));

    cmd_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Forwarded commands always target the back buffer, whatever the CPU wrote.
    always_comb begin
        fwd_word             = head[31:0];
        fwd_word[TOGGLE_BIT] = back_buf;
    end

    assign status = {frame_count, drop_err, back_buf, state, 7'b0, 5'(fifo_count)};

    // stage holds the word chosen this cycle; cmd_out presents it one cycle later
    // and falls back to the idle word (component 0) whenever nothing was chosen.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_DRAIN;
            id          <= IDLE_ID;
            back_buf    <= 1'b1;
            frame_count <= 16'h0;
            stage       <= 32'h0;
            cmd_out     <= 32'h0;
        end else begin
            stage   <= 32'h0;
            cmd_out <= stage;
            case (state)
                ST_DRAIN: begin
                    if (!fifo_empty) begin
                        if (head[32]) state <= ST_WAIT_VB;
                        else          stage <= fwd_word;
                    end
                end
                ST_WAIT_VB: begin
                    if (sof) begin
                        id    <= 6'd1;
                        state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    stage <= swap_word(id, back_buf);
                    id    <= id + 1'b1;
                    if (id == 6'(MAX_ID)) begin
                        back_buf    <= ~back_buf;
                        frame_count <= frame_count + 1'b1;
                        state       <= ST_DRAIN;
                    end
                end
                default: state <= ST_DRAIN;
            endcase
        end
    end

    // A new drop in the same cycle as a status read stays visible for the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'h0;
            drop_err <= 1'b0;
        end else begin
            if (rd_acc) readdata <= address ? status : 32'h0;
            if (wr_bad)                     drop_err <= 1'b1;
            else if (rd_acc && address)     drop_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// Directed bench for sprite_cmd_dispatcher: forwarding latency, commit/vblank swap,
// FIFO backpressure, dropped swap writes, status reads and reset during a swap.
module tb_sprite_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic        address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    sprite_cmd_dispatcher #(
        .FIFO_DEPTH  (16),
        .MAX_ID      (15),
        .VBLANK_LINE (480)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .hcount      (hcount),
        .vcount      (vcount),
        .cmd_out     (cmd_out)
    );

    always #5 clk = ~clk;

    // Every non-idle bus word, in order, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && cmd_out !== 32'h0) got_q.push_back(cmd_out);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sw(input int sid, input logic b);
        return (32'(sid) << 26) | 32'h001E0000 | (b ? 32'h00002000 : 32'h0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (waitrequest === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        assert (n < 100) else begin
            errors++;
            $error("FAIL %s: waitrequest high for %0d cycles, expected release", tag, n);
        end
    endtask

    task automatic avm_write(input logic addr, input logic [31:0] data, input string tag);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = addr;
        writedata  = data;
        wait_ready(tag);
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic avm_read(input logic addr, input logic [31:0] exp, input string tag);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = addr;
        wait_ready(tag);
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        check(tag, readdata, exp);
    endtask

    task automatic pulse_sof();
        hcount = 10'd0;
        vcount = 10'd480;
        tick();
        hcount = 10'd5;
        vcount = 10'd100;
    endtask

    task automatic do_reset();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        reset      = 1'b1;
        idle(2);
        reset      = 1'b0;
    endtask

    task automatic compare_queues(input string tag);
        check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s word %0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 1'b0;
        writedata  = 32'h0;
        hcount     = 10'd5;
        vcount     = 10'd100;
        idle(2);
        check("reset cmd_out", cmd_out, 32'h0);
        check("reset readdata", readdata, 32'h0);
        check("reset waitrequest", {31'b0, waitrequest}, 32'h0);
        reset = 1'b0;
        avm_read(1'b1, 32'h00004000, "status after reset");

        // Single command: two-cycle latency, bit13 stamped with back_buf=1, one cycle wide.
        avm_write(1'b0, 32'h24020400, "wr single");
        tick();
        check("single t+1 idle", cmd_out, 32'h0);
        tick();
        check("single stamped", cmd_out, 32'h24022400);
        tick();
        check("single one cycle", cmd_out, 32'h0);

        // Commit waits for vblank; a vblank line with hcount!=0 is not sof.
        got_q.delete();
        avm_write(1'b1, 32'hDEADBEEF, "wr commit");
        idle(10);
        check("wait_vb idle", cmd_out, 32'h0);
        avm_read(1'b1, 32'h00005000, "status wait_vb");
        hcount = 10'd3;
        vcount = 10'd480;
        tick();
        hcount = 10'd5;
        vcount = 10'd100;
        idle(3);
        check("no swap off hcount 0", 32'(got_q.size()), 32'h0);
        pulse_sof();
        tick();
        check("swap first cycle idle", cmd_out, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("swap id %0d", k), cmd_out, sw(k, 1'b1));
        end
        tick();
        check("idle after max id", cmd_out, 32'h0);
        avm_read(1'b1, 32'h00010000, "status after swap");

        // Commands around a commit pick up the buffer index current at their pop.
        do_reset();
        got_q.delete();
        exp_q.delete();
        avm_write(1'b0, 32'h08020001, "wr A");
        avm_write(1'b0, 32'h0C020002, "wr B");
        avm_write(1'b0, 32'h10020003, "wr C");
        avm_write(1'b1, 32'h0, "wr commit 2");
        avm_write(1'b0, 32'h14020004, "wr D");
        avm_write(1'b0, 32'h18022005, "wr E");
        idle(10);
        check("pre-vblank forwarded", 32'(got_q.size()), 32'h3);
        pulse_sof();
        idle(40);
        exp_q.push_back(32'h08022001);
        exp_q.push_back(32'h0C022002);
        exp_q.push_back(32'h10022003);
        for (int k = 1; k <= 15; k++) exp_q.push_back(sw(k, 1'b1));
        exp_q.push_back(32'h14020004);
        exp_q.push_back(32'h18020005);
        compare_queues("queued frame");
        avm_read(1'b1, 32'h00010000, "status queued frame");

        // Fill the FIFO while waiting for vblank; the 17th write is held, not lost.
        got_q.delete();
        exp_q.delete();
        avm_write(1'b1, 32'h0, "wr commit fill");
        idle(3);
        for (int i = 0; i < 15; i++) avm_write(1'b0, 32'h0C020100 + 32'(i), "wr fill");
        avm_read(1'b1, 32'h0001100F, "status 15 queued");
        avm_write(1'b0, 32'h0C02010F, "wr 16th");
        check("full waitrequest", {31'b0, waitrequest}, 32'h1);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 1'b0;
        writedata  = 32'h0C020110;
        idle(3);
        check("held write waitrequest", {31'b0, waitrequest}, 32'h1);
        pulse_sof();
        wait_ready("held write");
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        idle(40);
        for (int k = 1; k <= 15; k++) exp_q.push_back(sw(k, 1'b0));
        for (int i = 0; i < 17; i++) exp_q.push_back(32'h0C022100 + 32'(i));
        compare_queues("backpressure");

        // Swap action from the CPU is dropped and flagged until the next status read.
        got_q.delete();
        avm_write(1'b0, 32'h241E0000, "wr swap action");
        idle(5);
        check("dropped emits nothing", 32'(got_q.size()), 32'h0);
        avm_read(1'b1, 32'h0002C000, "status drop_err set");
        avm_read(1'b0, 32'h0, "read addr 0");
        avm_read(1'b1, 32'h00024000, "status drop_err cleared");

        // One-cycle reset in the middle of a swap sequence (id register at 7).
        avm_write(1'b1, 32'h0, "wr commit rst");
        avm_write(1'b0, 32'h08020011, "wr pending 1");
        avm_write(1'b0, 32'h08020012, "wr pending 2");
        idle(3);
        got_q.delete();
        pulse_sof();
        idle(6);
        check("swaps before reset", 32'(got_q.size()), 32'h4);
        check("swap id 5 on bus", cmd_out, sw(5, 1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset mid swap cmd_out", cmd_out, 32'h0);
        got_q.delete();
        idle(30);
        check("no words after reset", 32'(got_q.size()), 32'h0);
        check("waitrequest after reset", {31'b0, waitrequest}, 32'h0);
        avm_read(1'b1, 32'h00004000, "status after mid-swap reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
